// File: rtl/fetch_stage_if.sv
// Cache-side and decode-side signal bundle for the fetch stage.
// master: fetch stage; slave: cache + decode environment.
interface fetch_stage_if #(
   parameter int ADDR_WIDTH  = 64,
   parameter int INSTR_WIDTH = 32
);
   logic                   cache_read_enable;
   logic [ADDR_WIDTH-1:0]  cache_address;
   logic [2:0]             cache_data_size;
   logic [63:0]            cache_data;
   logic                   cache_send_enable;
   logic                   cache_send_complete;
   logic                   if_valid;
   logic                   if_ready;
   logic [INSTR_WIDTH-1:0] if_instr;
   logic [ADDR_WIDTH-1:0]  if_pc;

   modport master (
      output cache_read_enable, cache_address, cache_data_size, cache_send_complete,
      output if_valid, if_instr, if_pc,
      input  cache_data, cache_send_enable, if_ready
   );

   modport slave (
      input  cache_read_enable, cache_address, cache_data_size, cache_send_complete,
      input  if_valid, if_instr, if_pc,
      output cache_data, cache_send_enable, if_ready
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one read per instruction to the
// L1 cache, completes the send handshake and hands {pc, instr} to decode
// through a single-entry valid/ready slot. Redirects discard in-flight work.
// Optional: define FETCH_PERF_CNT_EN to add perf_fetched / perf_stall_cycles.
module fetch_stage #(
   parameter int                    ADDR_WIDTH  = 64,
   parameter int                    INSTR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
   parameter int                    PC_STEP     = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  fetch_enable,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   fetch_stage_if.master         bus
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]           perf_fetched,
   output logic [31:0]           perf_stall_cycles
`endif
);
   typedef enum logic [1:0] {S_IDLE, S_REQUEST, S_WAIT_DATA, S_ACK} state_t;

   localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(PC_STEP);

   state_t                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
   logic [ADDR_WIDTH-1:0]  req_pc_q, req_pc_d;
   logic [ADDR_WIDTH-1:0]  if_pc_q, if_pc_d;
   logic [INSTR_WIDTH-1:0] instr_q, instr_d;
   logic                   flush_q, flush_d;
   logic                   valid_q, valid_d;
   logic                   load;
   logic                   deliver;
   logic [ADDR_WIDTH-1:0]  redirect_tgt;

   // Redirect targets are word aligned; low two bits are dropped.
   assign redirect_tgt = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};

   // State, PC and output slot registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_IDLE;
         pc_q     <= RESET_PC;
         req_pc_q <= '0;
         if_pc_q  <= '0;
         instr_q  <= '0;
         flush_q  <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_pc_q <= req_pc_d;
         if_pc_q  <= if_pc_d;
         instr_q  <= instr_d;
         flush_q  <= flush_d;
         valid_q  <= valid_d;
      end
   end

   // Next state, capture decision and slot update; a redirect overrides both
   // a same-cycle capture and a same-cycle decode handshake.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      req_pc_d = req_pc_q;
      flush_d  = flush_q;
      load     = 1'b0;
      deliver  = valid_q && bus.if_ready;
      valid_d  = valid_q && !deliver;
      instr_d  = instr_q;
      if_pc_d  = if_pc_q;

      case (state_q)
         S_IDLE: begin
            // Only fetch when the slot is empty or being drained this cycle.
            if (fetch_enable && (!valid_q || bus.if_ready)) state_d = S_REQUEST;
         end
         S_REQUEST: begin
            req_pc_d = pc_q;
            state_d  = S_WAIT_DATA;
            if (redirect_valid) flush_d = 1'b1;
         end
         S_WAIT_DATA: begin
            if (bus.cache_send_enable) begin
               load    = !flush_q && !redirect_valid;
               flush_d = 1'b0;
               state_d = S_ACK;
            end else if (redirect_valid) begin
               flush_d = 1'b1;
            end
         end
         S_ACK: begin
            if (!bus.cache_send_enable) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (load) begin
         valid_d = 1'b1;
         instr_d = bus.cache_data[INSTR_WIDTH-1:0];
         if_pc_d = req_pc_q;
         pc_d    = req_pc_q + STEP;
      end

      if (redirect_valid) begin
         pc_d    = redirect_tgt;
         valid_d = 1'b0;
      end
   end

   assign bus.cache_read_enable   = (state_q == S_REQUEST);
   assign bus.cache_address       = (state_q == S_REQUEST) ? pc_q : '0;
   assign bus.cache_data_size     = 3'd4;
   assign bus.cache_send_complete = (state_q == S_ACK);
   assign bus.if_valid            = valid_q;
   assign bus.if_instr            = instr_q;
   assign bus.if_pc               = if_pc_q;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched_q, perf_stall_q;

   // Delivered-instruction and decode-stall counters; both wrap at 2^32.
   always_ff @(posedge clock) begin
      if (reset) begin
         perf_fetched_q <= '0;
         perf_stall_q   <= '0;
      end else begin
         if (deliver && !redirect_valid) perf_fetched_q <= perf_fetched_q + 32'd1;
         if (valid_q && !bus.if_ready)   perf_stall_q   <= perf_stall_q + 32'd1;
      end
   end

   assign perf_fetched      = perf_fetched_q;
   assign perf_stall_cycles = perf_stall_q;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a cache model with programmable hit
// latency, a decode sink, and a reference model of the expected PC stream.
module tb_fetch_stage;
   localparam logic [63:0] RST_PC = 64'h0;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        fetch_enable = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc = '0;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched, perf_stall_cycles;
`endif

   fetch_stage_if #(.ADDR_WIDTH(64), .INSTR_WIDTH(32)) bus ();

   fetch_stage #(.ADDR_WIDTH(64), .INSTR_WIDTH(32), .RESET_PC(RST_PC), .PC_STEP(4)) dut (
      .clock          (clock),
      .reset          (reset),
      .fetch_enable   (fetch_enable),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .bus            (bus)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetched      (perf_fetched),
      .perf_stall_cycles (perf_stall_cycles)
`endif
   );

   always #5 clock = ~clock;

   int n_vec = 0;
   int n_err = 0;

   // Memory image: addi-style encodings, 0x13 at 0, 0x93 at 4, 0x113 at 8...
   function automatic logic [31:0] mem_instr(input logic [63:0] a);
      return 32'h13 + (a[31:0] << 5);
   endfunction

   // ---------------- cache model ----------------
   int          lat = 2;
   bit          c_pend = 0;
   int          c_cnt = 0;
   logic [63:0] c_addr = '0;

   initial begin
      bus.cache_send_enable = 1'b0;
      bus.cache_data        = '0;
      bus.if_ready          = 1'b0;
   end

   always begin
      logic        s_re, s_cmp, s_rst;
      logic [63:0] s_addr;
      @(posedge clock);
      s_re   = bus.cache_read_enable;
      s_cmp  = bus.cache_send_complete;
      s_addr = bus.cache_address;
      s_rst  = reset;
      #1;
      if (s_rst) begin
         bus.cache_send_enable = 1'b0;
         c_pend = 0;
      end else begin
         if (bus.cache_send_enable && s_cmp) begin
            bus.cache_send_enable = 1'b0;
            c_pend = 0;
         end
         if (s_re) begin
            n_vec++;
            if (c_pend) begin
               n_err++;
               $display("FAIL cache_overlap: new request at %h while one outstanding", s_addr);
            end
            c_pend = 1;
            c_addr = s_addr;
            c_cnt  = lat;
         end
         if (c_pend && !bus.cache_send_enable) begin
            c_cnt--;
            if (c_cnt <= 0) begin
               bus.cache_send_enable = 1'b1;
               bus.cache_data = {~c_addr[31:0], mem_instr(c_addr)};
            end
         end
      end
   end

   // ---------------- reference model / monitor ----------------
   logic [63:0] exp_pc = RST_PC;
   int          del_cnt = 0;
   int          del_rst = 0;
   logic [63:0] dpc[$];
   logic [31:0] dins[$];
   bit          prev_hold = 0;
   logic [63:0] prev_pc;
   logic [31:0] prev_instr;

   always @(negedge clock) begin
      if (reset) begin
         exp_pc    = RST_PC;
         del_rst   = 0;
         prev_hold = 0;
      end else begin
         if (prev_hold) begin
            n_vec++;
            if (bus.if_valid !== 1'b1 || bus.if_pc !== prev_pc || bus.if_instr !== prev_instr) begin
               n_err++;
               $display("FAIL hold_stable: got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h",
                        bus.if_valid, bus.if_pc, bus.if_instr, prev_pc, prev_instr);
            end
         end
         if (bus.cache_read_enable) begin
            n_vec++;
            if (bus.if_valid !== 1'b0) begin
               n_err++;
               $display("FAIL req_while_full: if_valid=%b want 0", bus.if_valid);
            end
         end
         if (bus.if_valid && bus.if_ready && !redirect_valid) begin
            n_vec++;
            if (bus.if_pc !== exp_pc || bus.if_instr !== mem_instr(exp_pc)) begin
               n_err++;
               $display("FAIL deliver: got pc=%h ins=%h want pc=%h ins=%h",
                        bus.if_pc, bus.if_instr, exp_pc, mem_instr(exp_pc));
            end
            dpc.push_back(bus.if_pc);
            dins.push_back(bus.if_instr);
            del_cnt++;
            del_rst++;
            exp_pc = exp_pc + 64'd4;
         end
         if (redirect_valid) exp_pc = {redirect_pc[63:2], 2'b00};
         prev_hold  = bus.if_valid && !bus.if_ready && !redirect_valid;
         prev_pc    = bus.if_pc;
         prev_instr = bus.if_instr;
      end
   end

   // ---------------- helpers (timing only) ----------------
   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic wait_deliv(input int target, input int budget, output bit ok);
      int k = 0;
      while (del_cnt < target && k < budget) begin
         @(negedge clock); #1; k++;
      end
      ok = (del_cnt >= target);
      @(posedge clock); #1;
   endtask

   task automatic drain();
      redirect_valid = 1'b0;
      fetch_enable   = 1'b0;
      bus.if_ready   = 1'b1;
      cyc(20);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1; fetch_enable = 1'b0; bus.if_ready = 1'b0;
      cyc(3);
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock); #1;
         n_vec++;
         if (bus.cache_read_enable !== 1'b0 || bus.cache_send_complete !== 1'b0 ||
             bus.if_valid !== 1'b0 || bus.cache_address !== 64'h0 || bus.if_pc !== 64'h0 ||
             bus.if_instr !== 32'h0 || bus.cache_data_size !== 3'd4) begin
            n_err++;
            $display("FAIL reset_outputs: re=%b cmp=%b v=%b addr=%h pc=%h ins=%h sz=%0d want 0s and sz=4",
                     bus.cache_read_enable, bus.cache_send_complete, bus.if_valid,
                     bus.cache_address, bus.if_pc, bus.if_instr, bus.cache_data_size);
         end
`ifdef FETCH_PERF_CNT_EN
         n_vec++;
         if (perf_fetched !== 32'd0 || perf_stall_cycles !== 32'd0) begin
            n_err++;
            $display("FAIL reset_perf: got %0d/%0d want 0/0", perf_fetched, perf_stall_cycles);
         end
`endif
      end
      @(posedge clock); #1;
   endtask

   task automatic test_sequential();
      int d0 = del_cnt;
      bit ok;
      logic [63:0] wpc[3] = '{64'h0, 64'h4, 64'h8};
      logic [31:0] wins[3] = '{32'h13, 32'h93, 32'h113};
      lat = 2; bus.if_ready = 1'b1; fetch_enable = 1'b1;
      wait_deliv(d0 + 3, 200, ok);
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL seq_timeout: delivered %0d want %0d", del_cnt - d0, 3);
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (dpc[d0+i] !== wpc[i] || dins[d0+i] !== wins[i]) begin
               n_err++;
               $display("FAIL seq_%0d: got pc=%h ins=%h want pc=%h ins=%h",
                        i, dpc[d0+i], dins[d0+i], wpc[i], wins[i]);
            end
         end
      end
      drain();
   endtask

   task automatic test_stall();
      int k = 0;
      bit seen = 0;
      logic [63:0] hp;
      logic [31:0] hi;
      bus.if_ready = 1'b0; fetch_enable = 1'b1; lat = 2;
      while (!bus.if_valid && k < 100) begin @(negedge clock); #1; k++; end
      n_vec++;
      if (!bus.if_valid) begin
         n_err++;
         $display("FAIL stall_timeout: if_valid=%b want 1", bus.if_valid);
      end
      hp = bus.if_pc; hi = bus.if_instr;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock); #1;
         n_vec++;
         if (bus.if_valid !== 1'b1 || bus.if_pc !== hp || bus.if_instr !== hi || bus.cache_read_enable !== 1'b0) begin
            n_err++;
            $display("FAIL stall_hold: v=%b pc=%h ins=%h re=%b want v=1 pc=%h ins=%h re=0",
                     bus.if_valid, bus.if_pc, bus.if_instr, bus.cache_read_enable, hp, hi);
         end
      end
      @(posedge clock); #1;
      bus.if_ready = 1'b1;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clock); #1;
         if (bus.cache_read_enable) seen = 1;
      end
      n_vec++;
      if (!seen) begin
         n_err++;
         $display("FAIL stall_resume: no request seen, want one after if_ready=1");
      end
      drain();
   endtask

   task automatic test_redirect_wait();
      int k = 0;
      int d0;
      bit ok;
      lat = 3; bus.if_ready = 1'b1; fetch_enable = 1'b1;
      while (!bus.cache_read_enable && k < 50) begin @(negedge clock); #1; k++; end
      @(posedge clock); #1;           // now in WAIT_DATA
      d0 = del_cnt;
      redirect_valid = 1'b1; redirect_pc = 64'h1002;
      cyc(1);
      redirect_valid = 1'b0;
      wait_deliv(d0 + 1, 100, ok);
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL redir_wait_timeout: no delivery after redirect");
      end else begin
         n_vec++;
         if (dpc[d0] !== 64'h1000 || dins[d0] !== 32'h0002_0013) begin
            n_err++;
            $display("FAIL redir_wait: got pc=%h ins=%h want pc=%h ins=%h", dpc[d0], dins[d0], 64'h1000, 32'h0002_0013);
         end
      end
      drain();
   endtask

   task automatic test_redirect_handshake();
      int k = 0;
      int d0;
      bit ok;
`ifdef FETCH_PERF_CNT_EN
      logic [31:0] pf0;
`endif
      bus.if_ready = 1'b0; fetch_enable = 1'b1; lat = 1;
      while (!bus.if_valid && k < 100) begin @(negedge clock); #1; k++; end
      @(posedge clock); #1;
      fetch_enable = 1'b0;
      cyc(4);                          // let the ACK/IDLE tail settle
      d0 = del_cnt;
`ifdef FETCH_PERF_CNT_EN
      pf0 = perf_fetched;
`endif
      bus.if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h2000;
      cyc(1);
      redirect_valid = 1'b0;
      @(negedge clock); #1;
      n_vec++;
      if (bus.if_valid !== 1'b0 || del_cnt !== d0) begin
         n_err++;
         $display("FAIL redir_hs_kill: v=%b delivered=%0d want v=0 delivered=%0d", bus.if_valid, del_cnt, d0);
      end
`ifdef FETCH_PERF_CNT_EN
      n_vec++;
      if (perf_fetched !== pf0) begin
         n_err++;
         $display("FAIL redir_hs_perf: got %0d want %0d", perf_fetched, pf0);
      end
`endif
      @(posedge clock); #1;
      fetch_enable = 1'b1;
      wait_deliv(d0 + 1, 100, ok);
      n_vec++;
      if (!ok || dpc[d0] !== 64'h2000) begin
         n_err++;
         $display("FAIL redir_hs_next: ok=%b pc=%h want pc=%h", ok, ok ? dpc[d0] : 64'hx, 64'h2000);
      end
      drain();
   endtask

   task automatic test_wrap();
      int d0 = del_cnt;
      bit ok;
      logic [63:0] wpc[3] = '{64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0};
      redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFA;
      cyc(1);
      redirect_valid = 1'b0; fetch_enable = 1'b1; bus.if_ready = 1'b1; lat = 1;
      wait_deliv(d0 + 3, 200, ok);
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL wrap_timeout: delivered %0d want 3", del_cnt - d0);
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (dpc[d0+i] !== wpc[i]) begin
               n_err++;
               $display("FAIL wrap_%0d: got pc=%h want %h", i, dpc[d0+i], wpc[i]);
            end
         end
      end
      drain();
   endtask

   task automatic test_reset_ack();
      int k = 0;
      bit seen = 0;
      bus.if_ready = 1'b1; fetch_enable = 1'b1; lat = 2;
      while (!bus.cache_send_complete && k < 50) begin @(negedge clock); #1; k++; end
      @(posedge clock); #1;
      reset = 1'b1;
      @(negedge clock); #1;
      n_vec++;
      if (bus.cache_send_complete !== 1'b1) begin
         n_err++;
         $display("FAIL rst_ack_pre: cache_send_complete=%b want 1", bus.cache_send_complete);
      end
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock); #1;
      n_vec++;
      if (bus.cache_send_complete !== 1'b0 || bus.if_valid !== 1'b0 || bus.cache_read_enable !== 1'b0) begin
         n_err++;
         $display("FAIL rst_ack_post: cmp=%b v=%b re=%b want 0/0/0",
                  bus.cache_send_complete, bus.if_valid, bus.cache_read_enable);
      end
      for (int i = 0; i < 20 && !seen; i++) begin
         if (bus.cache_read_enable) begin
            seen = 1;
            n_vec++;
            if (bus.cache_address !== RST_PC) begin
               n_err++;
               $display("FAIL rst_ack_pc: got addr=%h want %h", bus.cache_address, RST_PC);
            end
         end else begin
            @(negedge clock); #1;
         end
      end
      n_vec++;
      if (!seen) begin
         n_err++;
         $display("FAIL rst_ack_restart: no request after reset");
      end
      @(posedge clock); #1;
      drain();
   endtask

   task automatic test_random();
      int d0 = del_cnt;
      for (int i = 0; i < 1500; i++) begin
         fetch_enable = ($urandom_range(0, 9) < 8);
         bus.if_ready = ($urandom_range(0, 9) < 7);
         lat          = $urandom_range(1, 4);
         if ($urandom_range(0, 99) < 3) begin
            redirect_valid = 1'b1;
            if ($urandom_range(0, 1) == 1) redirect_pc = {32'hFFFF_FFFF, 28'hFFF_FFFF, 4'($urandom)};
            else                           redirect_pc = {$urandom, $urandom};
         end else begin
            redirect_valid = 1'b0;
         end
         cyc(1);
      end
      drain();
      n_vec++;
      if (del_cnt - d0 < 50) begin
         n_err++;
         $display("FAIL rand_progress: delivered %0d want >= 50", del_cnt - d0);
      end
`ifdef FETCH_PERF_CNT_EN
      n_vec++;
      if (perf_fetched !== 32'(del_rst)) begin
         n_err++;
         $display("FAIL rand_perf: got %0d want %0d", perf_fetched, del_rst);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_redirect_wait();
      test_redirect_handshake();
      test_wrap();
      test_reset_ack();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
